fir_mc: RTL and testbench



---
 rtl/fir_mc_if.sv | 30 +++
 rtl/fir_mc.sv | 213 +++++++++++++++++++++
 tb/tb_fir_mc.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mc_if.sv
`default_nettype none
// ============================================================================
// Module  : fir_mc_if
// Brief   : Sample-in / result-out valid-ready bundle for fir_mc.
// Revision: 1.0
// ============================================================================
interface fir_mc_if #(
    parameter int DATA_WIDTH = 12,
    parameter int CH_W       = 1
);
    logic                         in_valid;
    logic                         in_ready;
    logic [CH_W-1:0]              in_ch;
    logic signed [DATA_WIDTH-1:0] x;
    logic                         out_valid;
    logic                         out_ready;
    logic [CH_W-1:0]              out_ch;
    logic signed [DATA_WIDTH-1:0] y;

    modport master (
        output in_valid, in_ch, x, out_ready,
        input  in_ready, out_valid, out_ch, y
    );

    modport slave (
        input  in_valid, in_ch, x, out_ready,
        output in_ready, out_valid, out_ch, y
    );
endinterface
`default_nettype wire

// File: rtl/fir_mc.sv
`default_nettype none
// ============================================================================
// Module  : fir_mc
// Brief   : Multi-channel bit-serial symmetric/antisymmetric FIR sharing one
//           serially loaded coefficient set. FIR_ROUND_EN selects round-half-up.
// Revision: 1.0
// ============================================================================
module fir_mc #(
    parameter int DATA_WIDTH  = 12,
    parameter int COEFF_WIDTH = 12,
    parameter int N_TAPS      = 9,
    parameter int N_CHANNELS  = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic coeff_load_in,
    input  wire logic coeff_in,
    input  wire logic sym_coeffs,
    fir_mc_if.slave   bus,
    output logic      busy
);
    localparam int N_COEFFS = (N_TAPS + 1) / 2;
    localparam int CH_W     = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    // Extra guard bits above DATA+COEFF+2 keep full-scale inputs on every tap from wrapping.
    localparam int ACC_W    = DATA_WIDTH + COEFF_WIDTH + 2 + $clog2(N_COEFFS);
    localparam int CHAIN_W  = N_COEFFS * COEFF_WIDTH;
    localparam int B_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int K_W      = (N_COEFFS > 1) ? $clog2(N_COEFFS) : 1;

    localparam logic signed [ACC_W-1:0] C_YMAX = ACC_W'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] C_YMIN = -C_YMAX - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] C_RND  = ACC_W'(64'sd1 <<< (COEFF_WIDTH-2));

    generate
        if ((N_TAPS % 2) == 0) begin : g_taps_must_be_odd
            $error("fir_mc: N_TAPS must be odd");
        end
        if (N_CHANNELS < 1) begin : g_channels_min
            $error("fir_mc: N_CHANNELS must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COEFF_LD = 2'd1,
        S_MAC      = 2'd2,
        S_OUT      = 2'd3
    } state_t;

    state_t                        state_q;
    logic signed [DATA_WIDTH-1:0]  hist_q [N_CHANNELS][N_TAPS];
    logic [CHAIN_W-1:0]            coeff_q;
    logic signed [ACC_W-1:0]       acc_q;
    logic [B_W-1:0]                b_q;
    logic [K_W-1:0]                k_q;
    logic [CH_W-1:0]               ch_q;
    logic                          sym_q;
    logic signed [DATA_WIDTH-1:0]  y_q;
    logic [CH_W-1:0]               out_ch_q;
    logic                          out_valid_q;
    logic                          busy_q;

    logic signed [DATA_WIDTH-1:0]  w_hist_sel [N_TAPS];
    logic                          w_bit_a;
    logic                          w_bit_b;
    logic signed [COEFF_WIDTH-1:0] w_coeff;
    logic signed [2:0]             w_pair;
    logic signed [COEFF_WIDTH+2:0] w_prod;
    logic signed [ACC_W-1:0]       w_term;
    logic signed [ACC_W-1:0]       w_acc_d;
    logic signed [ACC_W-1:0]       w_acc_r;
    logic signed [ACC_W-1:0]       w_shift;
    logic signed [DATA_WIDTH-1:0]  w_y_d;
    logic                          w_bit_last;
    logic                          w_mac_last;
    logic                          w_accept;
    logic                          w_ch_ok;

    assign bus.in_ready  = (state_q == S_IDLE) && !coeff_load_in;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.y         = y_q;
    assign busy          = busy_q;

    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_ch_ok    = ({1'b0, bus.in_ch} < (CH_W+1)'(N_CHANNELS));
    assign w_bit_last = (b_q == B_W'(DATA_WIDTH-1));
    assign w_mac_last = w_bit_last && (k_q == K_W'(N_COEFFS-1));
    assign w_hist_sel = hist_q[ch_q];

    // Tap pair k: newest-side sample k, oldest-side sample N_TAPS-1-k, coefficient c[k].
    always_comb begin
        w_bit_a = 1'b0;
        w_bit_b = 1'b0;
        w_coeff = '0;
        for (int k = 0; k < N_COEFFS; k++) begin
            if (k_q == K_W'(k)) begin
                w_bit_a = w_hist_sel[k][b_q];
                w_bit_b = w_hist_sel[N_TAPS-1-k][b_q];
                w_coeff = coeff_q[(N_COEFFS-k)*COEFF_WIDTH-1 -: COEFF_WIDTH];
            end
        end
    end

    always_comb begin
        w_pair = '0;
        if (k_q == K_W'(N_COEFFS-1)) begin
            w_pair = {2'b00, w_bit_a};
        end else if (sym_q) begin
            w_pair = {2'b00, w_bit_a} + {2'b00, w_bit_b};
        end else begin
            w_pair = {2'b00, w_bit_a} - {2'b00, w_bit_b};
        end
    end

    assign w_prod  = w_pair * w_coeff;
    assign w_term  = {{(ACC_W-COEFF_WIDTH-3){w_prod[COEFF_WIDTH+2]}}, w_prod} <<< b_q;
    // The sample MSB carries negative weight in two's complement.
    assign w_acc_d = w_bit_last ? (acc_q - w_term) : (acc_q + w_term);

`ifdef FIR_ROUND_EN
    assign w_acc_r = w_acc_d + C_RND;
`else
    assign w_acc_r = w_acc_d;
`endif

    assign w_shift = w_acc_r >>> (COEFF_WIDTH-1);

    always_comb begin
        w_y_d = w_shift[DATA_WIDTH-1:0];
        if (w_shift > C_YMAX) begin
            w_y_d = C_YMAX[DATA_WIDTH-1:0];
        end else if (w_shift < C_YMIN) begin
            w_y_d = C_YMIN[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            coeff_q     <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            k_q         <= '0;
            ch_q        <= '0;
            sym_q       <= 1'b0;
            y_q         <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int c = 0; c < N_CHANNELS; c++) begin
                for (int t = 0; t < N_TAPS; t++) begin
                    hist_q[c][t] <= '0;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (coeff_load_in) begin
                        state_q <= S_COEFF_LD;
                        busy_q  <= 1'b1;
                    end else if (w_accept && w_ch_ok) begin
                        acc_q   <= '0;
                        b_q     <= '0;
                        k_q     <= '0;
                        sym_q   <= sym_coeffs;
                        ch_q    <= bus.in_ch;
                        for (int t = N_TAPS-1; t > 0; t--) begin
                            hist_q[bus.in_ch][t] <= hist_q[bus.in_ch][t-1];
                        end
                        hist_q[bus.in_ch][0] <= bus.x;
                        state_q <= S_MAC;
                        busy_q  <= 1'b1;
                    end
                end
                S_COEFF_LD: begin
                    if (coeff_load_in) begin
                        coeff_q <= {coeff_q[CHAIN_W-2:0], coeff_in};
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_MAC: begin
                    acc_q <= w_acc_d;
                    if (w_bit_last) begin
                        b_q <= '0;
                        k_q <= k_q + K_W'(1);
                    end else begin
                        b_q <= b_q + B_W'(1);
                    end
                    if (w_mac_last) begin
                        y_q         <= w_y_d;
                        out_ch_q    <= ch_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fir_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_fir_mc
// Brief   : Scoreboard bench for fir_mc (3-channel instance) against an
//           arithmetic reference; honours FIR_ROUND_EN.
// Revision: 1.0
// ============================================================================
module tb_fir_mc;
    localparam int DW  = 12;
    localparam int CW  = 12;
    localparam int NT  = 9;
    localparam int NCH = 3;
    localparam int NC  = (NT + 1) / 2;
    localparam int CHW = 2;
    localparam int LAT = NC * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic coeff_load_in = 1'b0;
    logic coeff_in = 1'b0;
    logic sym_coeffs = 1'b0;
    logic busy;

    fir_mc_if #(.DATA_WIDTH(DW), .CH_W(CHW)) bus ();

    fir_mc #(
        .DATA_WIDTH (DW),
        .COEFF_WIDTH(CW),
        .N_TAPS     (NT),
        .N_CHANNELS (NCH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coeff_load_in(coeff_load_in),
        .coeff_in     (coeff_in),
        .sym_coeffs   (sym_coeffs),
        .bus          (bus.slave),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     ch;
        int     y;
        longint acc_cyc;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   e;
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint last_accept = 0;
    int     cm [NC];
    int     hm [NCH][NT];
    bit     rand_bp = 1'b0;

    always @(posedge clk) cyc++;

    function automatic int sx(input int v, input int w);
        return (v <<< (32 - w)) >>> (32 - w);
    endfunction

    // Direct evaluation of the filter equation on the model's history.
    function automatic int model_out(input int ch, input bit sym);
        longint a = 0;
        for (int k = 0; k < NC - 1; k++) begin
            if (sym) a += longint'(cm[k]) * (hm[ch][k] + hm[ch][NT-1-k]);
            else     a += longint'(cm[k]) * (hm[ch][k] - hm[ch][NT-1-k]);
        end
        a += longint'(cm[NC-1]) * hm[ch][NT/2];
`ifdef FIR_ROUND_EN
        a += longint'(1) <<< (CW - 2);
`endif
        a = a >>> (CW - 1);
        if (a > 2047)  return 2047;
        if (a < -2048) return -2048;
        return int'(a);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_coeffs(input bit with_valid);
        coeff_load_in = 1'b1;
        if (with_valid) begin
            bus.in_valid = 1'b1;
            bus.in_ch    = '0;
            bus.x        = 12'sd123;
        end
        @(negedge clk);
        if (with_valid) check("in_ready_during_coeff_load", bus.in_ready, 0);
        tick();
        bus.in_valid = 1'b0;
        check("busy_in_coeff_ld", busy, 1);
        for (int k = 0; k < NC; k++) begin
            for (int i = CW - 1; i >= 0; i--) begin
                coeff_in = cm[k][i];
                tick();
            end
        end
        coeff_load_in = 1'b0;
        tick();
    endtask

    task automatic send(input int ch, input int xv, input bit sym);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_ch    = ch[CHW-1:0];
        bus.x        = xv[DW-1:0];
        sym_coeffs   = sym;
        @(negedge clk);
        while (!bus.in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready still %0d after %0d cycles, expected 1", bus.in_ready, n);
            bus.in_valid = 1'b0;
        end else begin
            tick();
            bus.in_valid = 1'b0;
            last_accept  = cyc;
            if (ch < NCH) begin
                for (int t = NT - 1; t > 0; t--) hm[ch][t] = hm[ch][t-1];
                hm[ch][0] = xv;
                exp_q.push_back('{ch: ch, y: model_out(ch, sym), acc_cyc: cyc});
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: latency, hold stability and result comparison.
    logic                 prev_v = 1'b0;
    logic                 prev_r = 1'b0;
    logic signed [DW-1:0] prev_y = '0;
    logic [CHW-1:0]       prev_ch = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got out_ch %0d y %0d, expected no result", bus.out_ch, $signed(bus.y));
                end else begin
                    check("latency", cyc - exp_q[0].acc_cyc, LAT);
                end
            end
            if (bus.out_valid && prev_v && !prev_r) begin
                check("hold_y", $signed(bus.y), prev_y);
                check("hold_out_ch", bus.out_ch, prev_ch);
                check("hold_in_ready", bus.in_ready, 0);
            end
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_ch", bus.out_ch, e.ch);
                check("y", $signed(bus.y), e.y);
            end
            prev_v  = bus.out_valid;
            prev_r  = bus.out_ready;
            prev_y  = bus.y;
            prev_ch = bus.out_ch;
        end
    end

    initial begin
        int n;
        longint hs;
        bus.in_valid  = 1'b0;
        bus.in_ch     = '0;
        bus.x         = '0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < NCH; c++) for (int t = 0; t < NT; t++) hm[c][t] = 0;
        for (int k = 0; k < NC; k++) cm[k] = 0;

        repeat (3) tick();
        @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_y", $signed(bus.y), 0);
        check("reset_out_ch", bus.out_ch, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", bus.in_ready, 1);
        tick();
        rst = 1'b0;
        tick();

        // Impulse through a half-gain first tap, symmetric then antisymmetric.
        cm[0] = sx(32'h400, CW);
        load_coeffs(1'b0);
        send(0, 1000, 1'b1);
        for (int i = 0; i < 8; i++) send(0, 0, 1'b1);
        drain();
        send(1, 1000, 1'b0);
        for (int i = 0; i < 8; i++) send(1, 0, 1'b0);
        send(0, 0, 1'b1);
        drain();

        // Out-of-range channel: handshake completes, no result, histories untouched.
        send(3, 999, 1'b1);
        check("invalid_ch_stays_idle", busy, 0);
        repeat (LAT + 10) tick();
        send(0, 300, 1'b1);
        drain();

        // Output backpressure, then back-to-back acceptance.
        bus.out_ready = 1'b0;
        send(2, 777, 1'b1);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_seen", bus.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid_held", bus.out_valid, 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        tick();
        hs = cyc;
        check("bp_out_valid_falls", bus.out_valid, 0);
        send(2, -777, 1'b1);
        check("b2b_accept_cycle", last_accept, hs + 1);
        drain();

        // Rounding boundary around +-1 LSB.
        send(2, 1, 1'b1);
        send(2, -1, 1'b1);
        drain();

        // Saturation with full-scale coefficients; load overlaps a sample offer.
        for (int k = 0; k < NC; k++) cm[k] = sx(32'h7FF, CW);
        load_coeffs(1'b1);
        for (int i = 0; i < 9; i++) send(0, 2047, 1'b1);
        for (int i = 0; i < 9; i++) send(1, -2048, 1'b1);
        drain();

        // Randomised coefficients, samples, channels, modes and backpressure.
        for (int k = 0; k < NC; k++) cm[k] = sx(int'($urandom), CW);
        load_coeffs(1'b0);
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int v;
            case ($urandom_range(0, 5))
                0:       v = 2047;
                1:       v = -2048;
                default: v = sx(int'($urandom), DW);
            endcase
            send(int'($urandom_range(0, 3)), v, 1'($urandom_range(0, 1)));
        end
        drain();
        rand_bp = 1'b0;
        tick();
        tick();
        bus.out_ready = 1'b1;

        // Reset in the middle of a MAC pass aborts it.
        send(1, 1500, 1'b1);
        repeat (29) tick();
        rst = 1'b1;
        exp_q.delete();
        for (int c = 0; c < NCH; c++) for (int t = 0; t < NT; t++) hm[c][t] = 0;
        for (int k = 0; k < NC; k++) cm[k] = 0;
        tick();
        rst = 1'b0;
        check("midreset_out_valid", bus.out_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_y", $signed(bus.y), 0);
        check("midreset_out_ch", bus.out_ch, 0);
        repeat (LAT + 10) tick();
        check("midreset_no_result", bus.out_valid, 0);

        cm[0] = sx(32'h400, CW);
        load_coeffs(1'b0);
        send(1, 1000, 1'b1);
        for (int i = 0; i < 8; i++) send(1, 0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
